// File: rtl/encoder_seq.sv
// Sequential 4-to-2 encoder: sticky pending capture, valid/ready issue, saturating drop counter.
// Optional macro ENC_ROUND_ROBIN_EN switches selection from fixed priority to round-robin.
module encoder_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             decoder_00,
    input  logic             decoder_01,
    input  logic             decoder_02,
    input  logic             decoder_03,
    output logic [1:0]       num,
    output logic             num_valid,
    input  logic             num_ready,
    output logic [3:0]       pending,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [1:0]       num_q, num_d;
    logic             num_valid_q, num_valid_d;
    logic [3:0]       pending_q, pending_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [3:0]       line_s;
    logic             load_s;
    logic             found_s;
    logic [1:0]       sel_s;
    logic [3:0]       clr_s;
    logic [3:0]       drop_vec_s;
    logic [2:0]       drop_num_s;
    logic [CNT_W+2:0] drop_sum_s;
    logic [CNT_W+2:0] drop_max_s;

`ifdef ENC_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] cand_s;

    // Round-robin pick: search pending from rr_ptr+1 upward, wrapping 3 -> 0.
    always_comb begin
        found_s = 1'b0;
        sel_s   = 2'd0;
        cand_s  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand_s = rr_ptr_q + 2'(k + 1);
            if (!found_s && pending_q[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end
`else
    // Fixed-priority pick: lowest pending index wins.
    always_comb begin
        found_s = |pending_q;
        sel_s   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pending_q[k]) begin
                sel_s = 2'(k);
            end else begin
                sel_s = sel_s;
            end
        end
    end
`endif

    // Next-state: capture, issue handshake and saturating drop accounting.
    always_comb begin
        line_s      = {decoder_03, decoder_02, decoder_01, decoder_00};
        load_s      = ~num_valid_q | num_ready;
        clr_s       = 4'b0000;
        num_d       = num_q;
        num_valid_d = num_valid_q;
        drop_num_s  = 3'd0;

        if (load_s) begin
            if (found_s) begin
                num_d       = sel_s;
                num_valid_d = 1'b1;
                clr_s       = 4'b0001 << sel_s;
            end else begin
                num_valid_d = 1'b0;
            end
        end else begin
            num_valid_d = num_valid_q;
        end

        // A line that is set in the same cycle its bit clears keeps the bit and is not a drop.
        pending_d  = (pending_q & ~clr_s) | line_s;
        drop_vec_s = line_s & pending_q & ~clr_s;
        for (int k = 0; k < 4; k++) begin
            drop_num_s = drop_num_s + {2'b00, drop_vec_s[k]};
        end

        drop_sum_s = {3'b000, drop_cnt_q} + {{CNT_W{1'b0}}, drop_num_s};
        drop_max_s = {3'b000, {CNT_W{1'b1}}};
        if (drop_sum_s > drop_max_s) begin
            drop_cnt_d = {CNT_W{1'b1}};
        end else begin
            drop_cnt_d = drop_sum_s[CNT_W-1:0];
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    // Pointer follows the most recently selected line.
    always_comb begin
        if (load_s && found_s) begin
            rr_ptr_d = sel_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register; reset to 3 so the first search starts at line 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 2'd3;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // State registers; reset discards any held index.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q       <= 2'd0;
            num_valid_q <= 1'b0;
            pending_q   <= 4'b0000;
            drop_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
            pending_q   <= pending_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign num       = num_q;
    assign num_valid = num_valid_q;
    assign pending   = pending_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_encoder_seq.sv
// Directed testbench for encoder_seq: default-width instance plus a CNT_W=2 instance on shared inputs.
module tb_encoder_seq;

    logic       clk;
    logic       rst;
    logic [3:0] lines;
    logic       num_ready;

    logic [1:0] num_w, num_n;
    logic       valid_w, valid_n;
    logic [3:0] pend_w, pend_n;
    logic [7:0] drop_w;
    logic [1:0] drop_n;

    int checks;
    int errors;

    encoder_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .decoder_00(lines[0]), .decoder_01(lines[1]),
        .decoder_02(lines[2]), .decoder_03(lines[3]),
        .num(num_w), .num_valid(valid_w), .num_ready(num_ready),
        .pending(pend_w), .drop_cnt(drop_w)
    );

    encoder_seq #(.CNT_W(2)) dut_n (
        .clk(clk), .rst(rst),
        .decoder_00(lines[0]), .decoder_01(lines[1]),
        .decoder_02(lines[2]), .decoder_03(lines[3]),
        .num(num_n), .num_valid(valid_n), .num_ready(num_ready),
        .pending(pend_n), .drop_cnt(drop_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lines = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        num_ready = 1'b1;
        lines = 4'b1010;
        tick();
        lines = 4'b0101;
        tick();
        checks++; if (num_w !== 2'd0) begin errors++; $display("FAIL reset_num got %0d want 0", num_w); end
        checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_w); end
        checks++; if (pend_w !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b want 0000", pend_w); end
        checks++; if (drop_w !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_w); end
        checks++; if (drop_n !== 2'd0) begin errors++; $display("FAIL reset_drop_narrow got %0d want 0", drop_n); end
        rst = 1'b0;
        lines = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        num_ready = 1'b1;
        lines = 4'b0100;
        tick();
        lines = 4'b0000;
        checks++; if (pend_w !== 4'b0100) begin errors++; $display("FAIL single_pend1 got %b want 0100", pend_w); end
        checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL single_valid1 got %0b want 0", valid_w); end
        tick();
        checks++; if (num_w !== 2'd2) begin errors++; $display("FAIL single_num got %0d want 2", num_w); end
        checks++; if (valid_w !== 1'b1) begin errors++; $display("FAIL single_valid2 got %0b want 1", valid_w); end
        checks++; if (pend_w !== 4'b0000) begin errors++; $display("FAIL single_pend2 got %b want 0000", pend_w); end
        tick();
        checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL single_valid3 got %0b want 0", valid_w); end
        checks++; if (num_w !== 2'd2) begin errors++; $display("FAIL single_num_hold got %0d want 2", num_w); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        num_ready = 1'b1;
        lines = 4'b1111;
        tick();
        lines = 4'b0000;
        checks++; if (pend_w !== 4'b1111) begin errors++; $display("FAIL simul_pend got %b want 1111", pend_w); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (num_w !== 2'(i) || valid_w !== 1'b1) begin
                errors++; $display("FAIL simul_seq%0d got num=%0d valid=%0b want num=%0d valid=1", i, num_w, valid_w, i);
            end
        end
        tick();
        checks++; if (valid_w !== 1'b0 || pend_w !== 4'b0000) begin
            errors++; $display("FAIL simul_drain got valid=%0b pend=%b want 0 0000", valid_w, pend_w);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        num_ready = 1'b0;
        lines = 4'b0010;
        tick();
        lines = 4'b0000;
        tick();
        checks++; if (num_w !== 2'd1 || valid_w !== 1'b1) begin
            errors++; $display("FAIL bp_issue got num=%0d valid=%0b want 1 1", num_w, valid_w);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (num_w !== 2'd1 || valid_w !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d got num=%0d valid=%0b want 1 1", i, num_w, valid_w);
            end
        end
        num_ready = 1'b1;
        tick();
        checks++; if (valid_w !== 1'b0) begin errors++; $display("FAIL bp_release got %0b want 0", valid_w); end
    endtask

    task automatic test_drop_saturation();
        logic [1:0] exp_n [6];
        logic [7:0] exp_w [6];
        exp_n = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        exp_w = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        do_reset();
        num_ready = 1'b0;
        lines = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (drop_n !== exp_n[i]) begin
                errors++; $display("FAIL sat_narrow%0d got %0d want %0d", i, drop_n, exp_n[i]);
            end
            checks++; if (drop_w !== exp_w[i]) begin
                errors++; $display("FAIL sat_wide%0d got %0d want %0d", i, drop_w, exp_w[i]);
            end
        end
        checks++; if (pend_w[3] !== 1'b1 || num_w !== 2'd3 || valid_w !== 1'b1) begin
            errors++; $display("FAIL sat_state got pend=%b num=%0d valid=%0b want 1xxx 3 1", pend_w, num_w, valid_w);
        end
        lines = 4'b0000;
        num_ready = 1'b1;
        tick();
        checks++; if (num_w !== 2'd3 || valid_w !== 1'b1 || pend_n !== 4'b0000) begin
            errors++; $display("FAIL sat_reissue got num=%0d valid=%0b pend=%b want 3 1 0000", num_w, valid_w, pend_n);
        end
        tick();
        checks++; if (valid_w !== 1'b0 || drop_n !== 2'd3 || drop_w !== 8'd4) begin
            errors++; $display("FAIL sat_end got valid=%0b dn=%0d dw=%0d want 0 3 4", valid_w, drop_n, drop_w);
        end
    endtask

    task automatic test_multi_drop();
        do_reset();
        num_ready = 1'b0;
        lines = 4'b1111;
        tick();
        tick();
        lines = 4'b0000;
        checks++; if (drop_w !== 8'd3 || drop_n !== 2'd3) begin
            errors++; $display("FAIL multi_drop got dw=%0d dn=%0d want 3 3", drop_w, drop_n);
        end
        checks++; if (pend_w !== 4'b1111 || num_w !== 2'd0 || valid_w !== 1'b1) begin
            errors++; $display("FAIL multi_state got pend=%b num=%0d valid=%0b want 1111 0 1", pend_w, num_w, valid_w);
        end
        num_ready = 1'b1;
        tick();
        checks++; if (num_w !== 2'd0 || valid_w !== 1'b1 || pend_w !== 4'b1110) begin
            errors++; $display("FAIL multi_next got num=%0d valid=%0b pend=%b want 0 1 1110", num_w, valid_w, pend_w);
        end
    endtask

    task automatic test_set_wins_reset();
        do_reset();
        num_ready = 1'b1;
        lines = 4'b0001;
        tick();
        tick();
        checks++; if (num_w !== 2'd0 || valid_w !== 1'b1 || pend_w !== 4'b0001 || drop_w !== 8'd0) begin
            errors++; $display("FAIL setwins got num=%0d valid=%0b pend=%b drop=%0d want 0 1 0001 0", num_w, valid_w, pend_w, drop_w);
        end
        lines = 4'b0000;
        num_ready = 1'b0;
        tick();
        checks++; if (num_w !== 2'd0 || valid_w !== 1'b1 || pend_w !== 4'b0001) begin
            errors++; $display("FAIL setwins_hold got num=%0d valid=%0b pend=%b want 0 1 0001", num_w, valid_w, pend_w);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (num_w !== 2'd0 || valid_w !== 1'b0 || pend_w !== 4'b0000 || drop_w !== 8'd0) begin
            errors++; $display("FAIL midop_reset got num=%0d valid=%0b pend=%b drop=%0d want 0 0 0000 0", num_w, valid_w, pend_w, drop_w);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        lines = 4'b0000;
        num_ready = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_drop_saturation();
        test_multi_drop();
        test_set_wins_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
